// File: rtl/simplez_loader.sv
// Byte-stream program loader for the Simplez 512x12 memory.
// Optional read-back verify is enabled with `define SIMPLEZ_LOADER_VERIFY_EN.
module simplez_loader #(
  parameter logic [8:0] BASE_ADDR = 9'o000,
  parameter int         MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [8:0]  mem_addr,
  output logic        mem_wr,
  output logic [11:0] mem_din,
  input  logic [11:0] mem_dout,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_LO = 4'd1;
  localparam logic [3:0] S_LEN_HI = 4'd2;
  localparam logic [3:0] S_W_LO   = 4'd3;
  localparam logic [3:0] S_W_HI   = 4'd4;
  localparam logic [3:0] S_WRITE  = 4'd5;
  localparam logic [3:0] S_VRD    = 4'd6;
  localparam logic [3:0] S_VCMP   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERROR  = 4'd9;

  localparam logic [11:0] MAX_N = 12'(MAX_WORDS);

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [9:0]  count_next;
  logic [9:0]  count_plus;
  logic [7:0]  lo_byte;
  logic [11:0] n_words;
  logic [11:0] n_in;
  logic        accept;
  logic        hi_bad;
  logic        last_word;

  assign accept     = rx_valid & rx_ready;
  assign n_in       = {rx_data[3:0], lo_byte};
  assign hi_bad     = (rx_data[7:4] != 4'h0);
  assign count_plus = count + 10'd1;
  assign last_word  = ({2'b00, count_plus} == n_words);

`ifndef SIMPLEZ_LOADER_VERIFY_EN
  logic dout_unused;
  assign dout_unused = ^mem_dout;
`endif

  // Next-state and word-count logic.
  always_comb begin
    next_state = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_LEN_LO;
          count_next = 10'd0;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (accept) next_state = S_LEN_HI;
        else        next_state = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (!accept)               next_state = S_LEN_HI;
        else if (hi_bad)           next_state = S_ERROR;
        else if (n_in == 12'd0)    next_state = S_DONE;
        else if (n_in > MAX_N)     next_state = S_ERROR;
        else                       next_state = S_W_LO;
      end
      S_W_LO: begin
        if (accept) next_state = S_W_HI;
        else        next_state = S_W_LO;
      end
      S_W_HI: begin
        if (!accept)     next_state = S_W_HI;
        else if (hi_bad) next_state = S_ERROR;
        else             next_state = S_WRITE;
      end
`ifdef SIMPLEZ_LOADER_VERIFY_EN
      S_WRITE: next_state = S_VRD;
      S_VRD:   next_state = S_VCMP;
      S_VCMP: begin
        if (mem_dout != mem_din) begin
          next_state = S_ERROR;
        end else begin
          count_next = count_plus;
          if (last_word) next_state = S_DONE;
          else           next_state = S_W_LO;
        end
      end
`else
      S_WRITE: begin
        count_next = count_plus;
        if (last_word) next_state = S_DONE;
        else           next_state = S_W_LO;
      end
`endif
      S_DONE:  next_state = S_IDLE;
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      count    <= 10'd0;
      mem_addr <= BASE_ADDR;
      mem_din  <= 12'd0;
      lo_byte  <= 8'd0;
      n_words  <= 12'd0;
    end else begin
      state    <= next_state;
      rx_ready <= (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                  (next_state == S_W_LO)   || (next_state == S_W_HI);
      mem_wr   <= (next_state == S_WRITE);
      busy     <= (next_state != S_IDLE);
      count    <= count_next;
      mem_addr <= BASE_ADDR + count_next[8:0];
      if ((state == S_IDLE) && start) begin
        done  <= 1'b0;
        error <= 1'b0;
      end else begin
        if (next_state == S_DONE)  done  <= 1'b1;
        if (next_state == S_ERROR) error <= 1'b1;
      end
      if (accept && ((state == S_LEN_LO) || (state == S_W_LO))) lo_byte <= rx_data;
      if (accept && (state == S_LEN_HI)) n_words <= n_in;
      if (accept && (state == S_W_HI))   mem_din <= n_in;
    end
  end

endmodule

// File: tb/tb_simplez_loader.sv
// Randomized self-checking bench for simplez_loader against a stream-level reference model.
module tb_simplez_loader;

`ifdef SIMPLEZ_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_wr, busy, done, error;
  logic [8:0]  mem_addr;
  logic [11:0] mem_din, mem_dout;
  logic [9:0]  count;
  logic        w_rx_ready, w_wr, w_busy, w_done, w_error;
  logic [8:0]  w_addr;
  logic [11:0] w_din, w_dout;
  logic [9:0]  w_count;

  logic [11:0] mem0 [512];
  logic [11:0] exp_mem [512];
  logic [11:0] mem_w [512];
  logic [8:0]  wr_addrs_w [$];
  logic [7:0]  stim [$];
  int          wr_pulses;
  int          corrupt_addr = -1;
  int          checks = 0;
  int          errors = 0;
  logic        done_at_len;
  bit          timed_out;

  simplez_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .error(error), .count(count)
  );

  simplez_loader #(.BASE_ADDR(9'd511)) u_dut_wrap (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(w_rx_ready), .mem_addr(w_addr), .mem_wr(w_wr), .mem_din(w_din),
    .mem_dout(w_dout), .busy(w_busy), .done(w_done), .error(w_error), .count(w_count)
  );

  always #5 clk = ~clk;

  // Memories sample on negedge; read port registers the addressed word, optionally corrupted.
  always @(negedge clk) begin
    if (mem_wr) begin
      mem0[mem_addr] <= mem_din;
      wr_pulses = wr_pulses + 1;
    end
    mem_dout <= mem0[mem_addr] ^ ((corrupt_addr == int'(mem_addr)) ? 12'hfff : 12'h000);
    if (w_wr) begin
      mem_w[w_addr] <= w_din;
      wr_addrs_w.push_back(w_addr);
    end
    w_dout <= mem_w[w_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Stream-level reference: decode the byte list, update the expected memory image.
  task automatic model_run(input int corrupt, input int wlimit,
                           output int e_done, output int e_err, output int e_cnt, output int e_wr);
    logic [7:0] lo, hi;
    int n;
    e_done = 0; e_err = 0; e_cnt = 0; e_wr = 0;
    lo = stim[0]; hi = stim[1];
    if (hi[7:4] != 4'h0) begin e_err = 1; return; end
    n = int'({hi[3:0], lo});
    if (n == 0) begin e_done = 1; return; end
    if (n > 512) begin e_err = 1; return; end
    for (int i = 0; i < n; i++) begin
      lo = stim[2 + 2*i]; hi = stim[3 + 2*i];
      if (hi[7:4] != 4'h0) begin e_err = 1; return; end
      if (e_wr < wlimit) exp_mem[i % 512] = {hi[3:0], lo};
      e_wr++;
      if (VERIFY && i == corrupt) begin e_err = 1; return; end
      e_cnt = i + 1;
    end
    e_done = 1;
  endtask

  // Pulse start and feed stim with random valid gaps until the loader goes idle.
  task automatic run_load(input int pvalid, input int stop_wr);
    int idx = 0;
    int cyc = 0;
    bit hs;
    wr_pulses = 0;
    wr_addrs_w.delete();
    timed_out = 1'b0;
    done_at_len = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (1) begin
      if (idx < stim.size()) begin
        rx_valid = ($urandom_range(99) < pvalid);
        rx_data  = rx_valid ? stim[idx] : 8'($urandom);
      end else begin
        rx_valid = 1'b0;
      end
      hs = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (idx == 1) done_at_len = done;
        idx++;
      end
      cyc++;
      if (stop_wr > 0 && wr_pulses >= stop_wr) break;
      if (!busy) break;
      if (cyc >= 3000) begin timed_out = 1'b1; break; end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_load(input string tag, input int e_done, input int e_err,
                            input int e_cnt, input int e_wr);
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_error"}, 32'(error), 32'(e_err));
    check({tag, "_count"}, 32'(count), 32'(e_cnt));
    check({tag, "_wrs"}, 32'(wr_pulses), 32'(e_wr));
    for (int a = 0; a < 512; a++)
      check($sformatf("%s_mem%0d", tag, a), 32'(mem0[a]), 32'(exp_mem[a]));
  endtask

  task automatic push_word(input logic [11:0] w, input bit bad);
    stim.push_back(w[7:0]);
    stim.push_back({bad ? 4'h9 : 4'h0, w[11:8]});
  endtask

  task automatic full_case(input string tag, input int pvalid);
    int d, e, c, w;
    model_run(-1, 1 << 20, d, e, c, w);
    run_load(pvalid, 0);
    check_load(tag, d, e, c, w);
  endtask

  initial begin
    int d, e, c, w, n;
    logic [11:0] words [4];
    for (int a = 0; a < 512; a++) begin
      mem0[a] = 12'($urandom);
      exp_mem[a] = mem0[a];
      mem_w[a] = 12'h000;
    end
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);

    // Basic three-word load from the worked example.
    stim = '{8'h03, 8'h00, 8'h06, 8'h02, 8'h34, 8'h01, 8'h77, 8'h07};
    full_case("basic", 100);
    check("basic_m0", 32'(mem0[0]), 32'(12'o1006));
    check("basic_m1", 32'(mem0[1]), 32'(12'o0464));
    check("basic_m2", 32'(mem0[2]), 32'(12'o3567));

    // Empty load: done right after the length hi byte, no writes.
    stim = '{8'h00, 8'h00};
    full_case("zero", 100);
    check("zero_done_at_len", 32'(done_at_len), 32'd1);

    // Bad hi nibble on first word, then a clean load without reset.
    stim = '{8'h01, 8'h00, 8'h55, 8'h13};
    full_case("badhi", 100);
    stim = '{8'h01, 8'h00, 8'h55, 8'h03};
    full_case("after_err", 100);
    check("after_err_m0", 32'(mem0[0]), 32'(12'h355));

    // Over-length count.
    stim = '{8'h01, 8'h02};
    full_case("toolong", 100);

    // Address wrap on the BASE_ADDR=511 instance.
    stim = '{8'h02, 8'h00, 8'haa, 8'h01, 8'hbb, 8'h02};
    full_case("wrap", 70);
    check("wrap_n", 32'(wr_addrs_w.size()), 32'd2);
    check("wrap_a0", 32'(wr_addrs_w.size() > 0 ? wr_addrs_w[0] : 9'd0), 32'd511);
    check("wrap_a1", 32'(wr_addrs_w.size() > 1 ? wr_addrs_w[1] : 9'd1), 32'd0);
    check("wrap_m511", 32'(mem_w[511]), 32'(12'h1aa));
    check("wrap_m0", 32'(mem_w[0]), 32'(12'h2bb));
    check("wrap_done", 32'(w_done), 32'd1);

    // Random loads with random stalls and occasional bad hi bytes.
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 8));
      stim = '{8'(n), 8'h00};
      for (int i = 0; i < n; i++) push_word(12'($urandom), $urandom_range(19) == 0);
      full_case($sformatf("rnd%0d", t), int'($urandom_range(30, 100)));
    end

    // Four-word load with stalls, then the same shape aborted by rst after word 2.
    do_reset();
    for (int i = 0; i < 4; i++) words[i] = 12'($urandom);
    stim = '{8'h04, 8'h00};
    for (int i = 0; i < 4; i++) push_word(words[i], 1'b0);
    full_case("stall4", 40);
    stim = '{8'h04, 8'h00};
    for (int i = 0; i < 4; i++) push_word(words[i] ^ 12'h5a5, 1'b0);
    model_run(-1, 2, d, e, c, w);
    run_load(60, 2);
    check("rst_mid_timeout", 32'(timed_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_wr", 32'(mem_wr), 32'd0);
    check("rstm_ready", 32'(rx_ready), 32'd0);
    check("rstm_count", 32'(count), 32'd0);
    check("rstm_addr", 32'(mem_addr), 32'd0);
    check("rstm_din", 32'(mem_din), 32'd0);
    check("rstm_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstm_wrs", 32'(wr_pulses), 32'd2);
    for (int a = 0; a < 4; a++)
      check($sformatf("rstm_mem%0d", a), 32'(mem0[a]), 32'(exp_mem[a]));
    check("rstm_m2_old", 32'(mem0[2]), 32'(words[2]));

    // Read-back corruption on word 1: only the verify build notices.
    do_reset();
    corrupt_addr = 1;
    stim = '{8'h03, 8'h00};
    for (int i = 0; i < 3; i++) push_word(12'($urandom), 1'b0);
    model_run(1, 1 << 20, d, e, c, w);
    run_load(100, 0);
    check_load("corrupt", d, e, c, w);
    corrupt_addr = -1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
